// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity modes, receiver state encoding
// and the mid-bit position helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_BREAK
  } rx_state_t;

  // Baud count at the centre of a bit period.
  function automatic int mid_count(input int clk_per_bit);
    return (clk_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-word bundle between the UART receiver (master) and its consumer (slave).
// o_valid is a one-cycle strobe with no back-pressure: the consumer must take
// o_data and the error flags in the cycle o_valid is high.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (output o_data, o_valid, o_parity_err, o_frame_err, o_busy);
  modport slave  (input  o_data, o_valid, o_parity_err, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the RX pin plus a 3-tap majority voter that
// looks at the synchronised line around the middle of each bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter  int CLK_PER_BIT = 868,
  localparam int CW          = $clog2(CLK_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx,
  input  logic [CW-1:0] baud_cnt,
  output logic          rx_s,
  output logic          maj_bit
);

  localparam int            MID    = mid_count(CLK_PER_BIT);
  localparam logic [CW-1:0] MID_M1 = CW'(MID - 1);
  localparam logic [CW-1:0] MID_0  = CW'(MID);

  logic sync1, sync2, s0, s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      s0    <= 1'b1;
      s1    <= 1'b1;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
      if (baud_cnt == MID_M1) s0 <= sync2;
      if (baud_cnt == MID_0)  s1 <= sync2;
    end
  end

  // Third vote is the live line at MID+1, when the FSM consumes maj_bit.
  assign rx_s    = sync2;
  assign maj_bit = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start/data/parity/stop framing with majority-voted bits,
// delivering each word with a one-cycle valid strobe and error flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_rx,
  uart_rx_frame_if.master rx_if,
  output rx_state_t dbg_state
);

  localparam int                   CW        = $clog2(CLK_PER_BIT);
  localparam int                   IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]        MID_P1    = CW'(mid_count(CLK_PER_BIT) + 1);
  localparam logic [CW-1:0]        LAST_CNT  = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0]        LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = (STOP_BITS == 2);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err, frm_err;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, busy_q;
  logic                 rx_s, maj_bit;

  uart_rx_sampler #(.CLK_PER_BIT(CLK_PER_BIT)) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rx     (i_rx),
    .baud_cnt (cnt),
    .rx_s     (rx_s),
    .maj_bit  (maj_bit)
  );

  wire  mid_tick = (cnt == MID_P1);
  wire  end_tick = (cnt == LAST_CNT);
  wire  par_exp  = (PARITY == PARITY_EVEN) ? ^shift : ~^shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= ST_START;
            busy_q  <= 1'b1;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        ST_START: begin
          if (mid_tick && maj_bit) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (end_tick) begin
            state <= ST_DATA;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (mid_tick) shift[idx] <= maj_bit;
          if (end_tick) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (mid_tick) par_err <= (maj_bit != par_exp);
          if (end_tick) begin
            state <= ST_STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (mid_tick && !maj_bit) frm_err <= 1'b1;
          // The last stop bit ends at its mid-point so the next start edge is not missed.
          if (mid_tick && (stop_idx == LAST_STOP)) begin
            state    <= ST_DONE;
            cnt      <= '0;
            stop_idx <= 1'b0;
          end else if (end_tick) begin
            cnt      <= '0;
            stop_idx <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          data_q  <= shift;
          perr_q  <= (PARITY != PARITY_NONE) && par_err;
          ferr_q  <= frm_err;
          valid_q <= 1'b1;
          cnt     <= '0;
          if (frm_err) begin
            state <= ST_BREAK;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.o_data       = data_q;
  assign rx_if.o_valid      = valid_q;
  assign rx_if.o_parity_err = perr_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_busy       = busy_q;
  assign dbg_state          = state;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver. It supports configurable data width, optional odd/even parity, and 1 or 2 stop bits. Line samples are taken as a 3-point majority vote at mid-bit. Each received word is delivered with a one-cycle valid strobe plus parity and framing error flags. It sits between the board RX pin and downstream command/FIFO logic.

Parameters:
- CLK_PER_BIT, 868: system clocks per bit (100 MHz / 115200). Must be >= 8.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_rx  in  1  raw serial line, asynchronous, idle high.
- o_data  out  DATA_BITS  last received word, LSB first on the wire.
- o_valid  out  1  one-cycle pulse when o_data/error flags update.
- o_parity_err  out  1  parity mismatch for the word accompanying o_valid.
- o_frame_err  out  1  a stop bit sampled low for that word.
- o_busy  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops = 1, state = IDLE, counters = 0.
  - o_data = 0; o_valid, o_parity_err, o_frame_err, o_busy = 0.
- Input conditioning: 2-flop synchroniser; the FSM reads only the synchronised bit rx_s.
- Baud counter: width $clog2(CLK_PER_BIT), counts 0..CLK_PER_BIT-1 and wraps to 0. MID = (CLK_PER_BIT-1)/2.
- Majority sampling: samples rx_s at counts MID-1, MID, MID+1. Bit value = majority of the 3, registered at count MID+1.
- States:
  - IDLE: counter = 0. rx_s = 0 -> START, o_busy = 1.
  - START: majority at MID+1 = 1 -> IDLE (glitch rejected, no o_valid). Otherwise continue; at count CLK_PER_BIT-1 -> DATA, bit index = 0.
  - DATA: each bit period stores the majority into shift position [bit index], LSB first. At end of period, if bit index = DATA_BITS-1 -> PARITY (PARITY != 0) or STOP; else increment index.
  - PARITY: compares the majority bit with the XOR of the data (even) or its complement (odd), latching a mismatch flag. End of period -> STOP.
  - STOP: for each of STOP_BITS periods, a majority of 0 sets the frame-error flag. The last stop period ends early, at count MID+1, then -> DONE, so resync fits inside the stop bit.
  - DONE (1 cycle): o_data <= word, o_parity_err/o_frame_err <= flags, o_valid = 1.
    - Frame error -> BREAK, else -> IDLE.
  - BREAK: waits for rx_s = 1 for one full cycle, then -> IDLE. This stops a held-low line (break) from producing repeated frames.
- o_busy: deasserts on entry to IDLE.
- Output holding: o_data and the error flags hold until the next DONE.
- Error-flag validity: flags are meaningful only with o_valid. PARITY = 0 forces o_parity_err = 0.
- Latency: o_valid rises 2 cycles (DONE entry) after the final stop-bit majority sample, plus 2 cycles of synchroniser delay from the pin.
- Back-to-back frames: a new start edge during IDLE immediately after DONE must be accepted with no lost frame. There is no overrun detection; downstream must consume on o_valid.
- Reset mid-frame: returns to the reset state at once. No o_valid is generated for the partial frame.
- Counter/index rules: index width $clog2(DATA_BITS). All counters reset to 0 on every state transition except within DATA.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, DONE, BREAK).
  - Helper function for the MID computation.
- Sub-module uart_rx_sampler:
  - 2-flop synchroniser plus 3-tap majority voter.
  - Inputs clk, rst_n, i_rx, baud count; outputs rx_s, maj_bit.
  - Shared later with uart_tx loopback checking.

Test Plan:
1. CLK_PER_BIT=16, 8N1, send 0xA5 -> one o_valid pulse, o_data=0xA5, both errors 0, o_busy low before the next frame.
2. 8E1, send 0x3C with parity 1 (wrong; even requires 0) -> o_data=0x3C, o_parity_err=1. Then 0x3C with parity 0 -> o_parity_err=0.
3. 7O2, send 0x55 with the second stop bit driven 0 -> o_frame_err=1. Hold line low 5 bit times -> no further o_valid until line returns high, then 0x12 received cleanly.
4. 6-cycle low glitch in idle -> no o_valid, o_busy returns low within CLK_PER_BIT cycles. Also a single-cycle glitch at a data-bit mid-point -> majority rejects it, word unchanged.
5. Back-to-back 9N1 frames 0x1FF, 0x000 with zero idle gap -> two o_valid pulses, correct data in order.
6. Assert rst_n low mid-DATA of frame 0x81 -> all outputs 0 immediately. After release, the next full frame 0x7E is received with no spurious o_valid.
